// File: rtl/wm_pkg.sv
// Shared types and constants for the washing-machine phase sequencer.
package wm_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } wm_state_e;

  // Conventional meaning of the first four phases of a cycle.
  localparam int unsigned PH_SOAK  = 0;
  localparam int unsigned PH_WASH  = 1;
  localparam int unsigned PH_RINSE = 2;
  localparam int unsigned PH_SPIN  = 3;

endpackage

// File: rtl/wm_next_phase.sv
// Priority search for the lowest set mask bit above (or, if INCLUSIVE, at or above) cur.
module wm_next_phase #(
  parameter int unsigned NUM_PHASES = 4,
  parameter bit          INCLUSIVE  = 1'b0
) (
  input  logic [NUM_PHASES-1:0]         mask,
  input  logic [$clog2(NUM_PHASES)-1:0] cur,
  output logic [$clog2(NUM_PHASES)-1:0] next_idx,
  output logic                          none_left
);

  localparam int unsigned IW = $clog2(NUM_PHASES);

  int unsigned cur_i;

  // Scan high to low so the lowest qualifying index is written last.
  always_comb begin
    next_idx  = '0;
    none_left = 1'b1;
    cur_i     = 32'(cur);
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (mask[NUM_PHASES-1-i] &&
          (INCLUSIVE ? (NUM_PHASES-1-i >= cur_i) : (NUM_PHASES-1-i > cur_i))) begin
        next_idx  = IW'(NUM_PHASES-1-i);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wm_phase_sequencer.sv
// Programmable multi-phase washing-machine sequencer with pause/resume and phase skipping.
// Optional pause timeout enabled by defining WM_PAUSE_TIMEOUT_EN.
module wm_phase_sequencer
  import wm_pkg::*;
#(
  parameter int unsigned NUM_PHASES  = 4,
  parameter int unsigned NUM_MODES   = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_LEN = 16,
  parameter int unsigned PAUSE_MAX   = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          cancel,
  input  logic                          lid_open,
  input  logic                          power_on,
  input  logic [$clog2(NUM_MODES)-1:0]  mode_sel,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_MODES)-1:0]  cfg_mode,
  input  logic [$clog2(NUM_PHASES)-1:0] cfg_phase,
  input  logic [CNT_W-1:0]              cfg_len,
  output logic [1:0]                    state,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic [NUM_PHASES-1:0]         phase_en,
  output logic [CNT_W-1:0]              counter_out,
  output logic                          busy,
  output logic                          done,
  output logic                          abort_fault
);

  localparam int unsigned IW = $clog2(NUM_PHASES);
  localparam int unsigned MW = $clog2(NUM_MODES);

  wm_state_e       state_q, state_d;
  logic [IW-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MW-1:0]   mode_q, mode_d;
  logic            fault_q, fault_d;
  logic            arm_q, arm_d;

  logic [CNT_W-1:0] len_tab [NUM_MODES][NUM_PHASES];

  logic [NUM_PHASES-1:0] start_mask, run_mask;
  logic [IW-1:0]         start_idx, adv_idx;
  logic                  start_none, adv_none;
  logic [CNT_W-1:0]      cur_len;
  logic                  pause_cond, accept, pause_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned m = 0; m < NUM_MODES; m++)
        for (int unsigned p = 0; p < NUM_PHASES; p++)
          len_tab[m][p] <= CNT_W'(DEFAULT_LEN);
    end else if (state_q == ST_IDLE && cfg_we && 32'(cfg_phase) < NUM_PHASES) begin
      len_tab[cfg_mode][cfg_phase] <= cfg_len;
    end
  end

  always_comb begin
    start_mask = '0;
    run_mask   = '0;
    for (int unsigned p = 0; p < NUM_PHASES; p++) begin
      start_mask[p] = (len_tab[mode_sel][p] != '0);
      run_mask[p]   = (len_tab[mode_q][p] != '0);
    end
  end

  assign cur_len = len_tab[mode_q][phase_q];

  wm_next_phase #(.NUM_PHASES(NUM_PHASES), .INCLUSIVE(1'b1)) u_start_search (
    .mask      (start_mask),
    .cur       ('0),
    .next_idx  (start_idx),
    .none_left (start_none)
  );

  wm_next_phase #(.NUM_PHASES(NUM_PHASES), .INCLUSIVE(1'b0)) u_adv_search (
    .mask      (run_mask),
    .cur       (phase_q),
    .next_idx  (adv_idx),
    .none_left (adv_none)
  );

`ifdef WM_PAUSE_TIMEOUT_EN
  localparam int unsigned PW = $clog2(PAUSE_MAX + 1);
  logic [PW-1:0] pcnt_q, pcnt_d;

  // Restarts from zero on every entry because it only counts while already paused.
  assign pcnt_d        = (state_q == ST_PAUSE) ? pcnt_q + 1'b1 : '0;
  assign pause_expired = (pcnt_q == PW'(PAUSE_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end
`else
  logic pause_max_unused;
  assign pause_max_unused = (PAUSE_MAX == 0);
  assign pause_expired    = 1'b0;
`endif

  assign pause_cond = !power_on || lid_open;
  // Start is armed only after it has been seen low, so a held start cannot retrigger.
  assign accept     = start && arm_q && power_on && !lid_open;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    fault_d = fault_q;
    arm_d   = arm_q | !start;
    if (cancel) begin
      state_d = ST_IDLE;
      phase_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            mode_d  = mode_sel;
            fault_d = 1'b0;
            arm_d   = 1'b0;
            cnt_d   = '0;
            if (start_none) begin
              state_d = ST_DONE;
              phase_d = '0;
            end else begin
              state_d = ST_RUN;
              phase_d = start_idx;
            end
          end
        end
        ST_RUN: begin
          if (pause_cond) begin
            state_d = ST_PAUSE;
          end else if (cnt_q == cur_len - CNT_W'(1)) begin
            cnt_d = '0;
            if (adv_none) begin
              state_d = ST_DONE;
              phase_d = '0;
            end else begin
              phase_d = adv_idx;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_PAUSE: begin
          if (!pause_cond) begin
            state_d = ST_RUN;
          end else if (pause_expired) begin
            state_d = ST_IDLE;
            phase_d = '0;
            cnt_d   = '0;
            fault_d = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      fault_q <= 1'b0;
      arm_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fault_q <= fault_d;
      arm_q   <= arm_d;
    end
  end

  always_comb begin
    phase_en = '0;
    if (state_q == ST_RUN) phase_en[phase_q] = 1'b1;
  end

  assign state       = state_q;
  assign phase_idx   = phase_q;
  assign counter_out = cnt_q;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done        = (state_q == ST_DONE);
  assign abort_fault = fault_q;

endmodule

// File: tb/tb_wm_phase_sequencer.sv
// Directed bench for wm_phase_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_wm_phase_sequencer;
  import wm_pkg::*;

`ifdef WM_PAUSE_TIMEOUT_EN
  localparam int unsigned PMAX    = 20;
  localparam int unsigned D_PAUSE = 15;
`else
  localparam int unsigned PMAX    = 1000;
  localparam int unsigned D_PAUSE = 30;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n, start, cancel, lid_open, power_on, cfg_we;
  logic [1:0]  mode_sel, cfg_mode, cfg_phase;
  logic [31:0] cfg_len;
  logic [1:0]  state, phase_idx;
  logic [3:0]  phase_en;
  logic [31:0] counter_out;
  logic        busy, done, abort_fault;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wm_phase_sequencer #(
    .NUM_PHASES(4), .NUM_MODES(4), .CNT_W(32), .DEFAULT_LEN(16), .PAUSE_MAX(PMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel), .lid_open(lid_open),
    .power_on(power_on), .mode_sel(mode_sel), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
    .cfg_phase(cfg_phase), .cfg_len(cfg_len), .state(state), .phase_idx(phase_idx),
    .phase_en(phase_en), .counter_out(counter_out), .busy(busy), .done(done),
    .abort_fault(abort_fault)
  );

  typedef struct {
    logic        start, cancel, lid, pwr;
    logic [1:0]  msel;
    logic        we;
    logic [1:0]  cm, cp;
    logic [31:0] len;
    logic [1:0]  st, idx;
    logic [31:0] cnt;
    logic [3:0]  en;
    logic        dn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic c, logic l, logic p, logic [1:0] ms, logic we,
                              logic [1:0] cm, logic [1:0] cp, logic [31:0] len,
                              logic [1:0] st, logic [1:0] idx, logic [31:0] cnt,
                              logic [3:0] en, logic dn);
    vec_t v;
    v.start = s; v.cancel = c; v.lid = l; v.pwr = p; v.msel = ms; v.we = we;
    v.cm = cm; v.cp = cp; v.len = len; v.st = st; v.idx = idx; v.cnt = cnt;
    v.en = en; v.dn = dn;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [1:0] st, input logic [1:0] idx,
                         input logic [31:0] cnt, input logic [3:0] en, input logic dn);
    chk({nm, ".state"}, 32'(state), 32'(st));
    chk({nm, ".phase_idx"}, 32'(phase_idx), 32'(idx));
    chk({nm, ".counter"}, counter_out, cnt);
    chk({nm, ".phase_en"}, 32'(phase_en), 32'(en));
    chk({nm, ".done"}, 32'(done), 32'(dn));
    chk({nm, ".busy"}, 32'(busy), 32'((st == S_RUN) || (st == S_PAUSE)));
  endtask

  task automatic cfg(input logic [1:0] m, input logic [1:0] p, input logic [31:0] len);
    cfg_we = 1'b1; cfg_mode = m; cfg_phase = p; cfg_len = len;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic begin_cycle(input logic [1:0] m);
    start = 1'b1; mode_sel = m;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; lid_open = 1'b0; power_on = 1'b1;
    mode_sel = '0; cfg_we = 1'b0; cfg_mode = '0; cfg_phase = '0; cfg_len = '0;

    // s  c  l  p  msel we cm cp len   st      idx cnt en     dn
    vecs.push_back(mk(0,0,0,1, 0, 1, 2, 0, 1,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0,0,0,1, 0, 1, 2, 1, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0,0,0,1, 0, 1, 2, 2, 2,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0,0,0,1, 0, 1, 2, 3, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1,0,0,1, 2, 0, 0, 0, 0,  S_RUN,  0, 0, 4'b0001, 0));
    vecs.push_back(mk(1,0,0,1, 2, 0, 0, 0, 0,  S_RUN,  2, 0, 4'b0100, 0));
    vecs.push_back(mk(1,0,0,1, 2, 0, 0, 0, 0,  S_RUN,  2, 1, 4'b0100, 0));
    vecs.push_back(mk(1,0,0,1, 2, 0, 0, 0, 0,  S_DONE, 0, 0, 4'b0000, 1));
    vecs.push_back(mk(1,0,0,1, 2, 0, 0, 0, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1,0,0,1, 2, 0, 0, 0, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0,0,0,1, 2, 0, 0, 0, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1,0,1,1, 2, 0, 0, 0, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1,0,0,0, 2, 0, 0, 0, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1,0,0,1, 2, 0, 0, 0, 0,  S_RUN,  0, 0, 4'b0001, 0));
    vecs.push_back(mk(0,0,0,1, 2, 1, 2, 2, 9,  S_RUN,  2, 0, 4'b0100, 0));
    vecs.push_back(mk(0,0,0,1, 2, 0, 0, 0, 0,  S_RUN,  2, 1, 4'b0100, 0));
    vecs.push_back(mk(0,0,0,1, 2, 0, 0, 0, 0,  S_DONE, 0, 0, 4'b0000, 1));
    vecs.push_back(mk(0,0,0,1, 2, 0, 0, 0, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1,0,0,1, 2, 0, 0, 0, 0,  S_RUN,  0, 0, 4'b0001, 0));
    vecs.push_back(mk(0,1,0,1, 2, 0, 0, 0, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0,0,0,1, 2, 0, 0, 0, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0,0,0,1, 0, 1, 2, 0, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0,0,0,1, 0, 1, 2, 2, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1,0,0,1, 2, 0, 0, 0, 0,  S_DONE, 0, 0, 4'b0000, 1));
    vecs.push_back(mk(0,0,0,1, 2, 0, 0, 0, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1,1,0,1, 0, 0, 0, 0, 0,  S_IDLE, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0,0,0,1, 0, 0, 0, 0, 0,  S_IDLE, 0, 0, 4'b0000, 0));

    #12;
    chk_all("reset", S_IDLE, 0, 0, 4'b0000, 0);
    chk("reset.abort_fault", 32'(abort_fault), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default table, mode 0: four phases of 16 cycles.
    begin_cycle(0);
    for (int k = 0; k < 64; k++) begin
      chk_all($sformatf("dflt.k%0d", k), S_RUN, 2'(k / 16), 32'(k % 16),
              4'(1 << (k / 16)), 0);
      tick();
    end
    chk_all("dflt.done", S_DONE, 0, 0, 4'b0000, 1);
    tick();
    chk_all("dflt.idle", S_IDLE, 0, 0, 4'b0000, 0);

    // Spin-only mode 3.
    cfg(3, 0, 0); cfg(3, 1, 0); cfg(3, 2, 0); cfg(3, 2'(PH_SPIN), 5);
    begin_cycle(3);
    for (int k = 0; k < 5; k++) begin
      chk_all($sformatf("spin.k%0d", k), S_RUN, 2'(PH_SPIN), 32'(k), 4'b1000, 0);
      tick();
    end
    chk_all("spin.done", S_DONE, 0, 0, 4'b0000, 1);
    tick();
    chk_all("spin.idle", S_IDLE, 0, 0, 4'b0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; cancel = vecs[i].cancel; lid_open = vecs[i].lid;
      power_on = vecs[i].pwr; mode_sel = vecs[i].msel; cfg_we = vecs[i].we;
      cfg_mode = vecs[i].cm; cfg_phase = vecs[i].cp; cfg_len = vecs[i].len;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].idx, vecs[i].cnt, vecs[i].en, vecs[i].dn);
    end
    start = 1'b0; cancel = 1'b0; lid_open = 1'b0; power_on = 1'b1; cfg_we = 1'b0;

    // Asynchronous reset mid-run also restores the table (mode 2 was all-zero).
    begin_cycle(0);
    tick(); tick();
    chk_all("prerst", S_RUN, 0, 2, 4'b0001, 0);
    #2 rst_n = 1'b0;
    #1 chk_all("midrst", S_IDLE, 0, 0, 4'b0000, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin_cycle(2);
    chk_all("rst.tab", S_RUN, 0, 0, 4'b0001, 0);
    cancel = 1'b1; tick(); cancel = 1'b0;

    // Power loss at phase 1, count 7.
    begin_cycle(1);
    for (int k = 0; k < 23; k++) tick();
    chk_all("pwr.pre", S_RUN, 1, 7, 4'b0010, 0);
    power_on = 1'b0;
    for (int k = 0; k < D_PAUSE; k++) begin
      tick();
      chk_all($sformatf("pwr.p%0d", k), S_PAUSE, 1, 7, 4'b0000, 0);
    end
    power_on = 1'b1;
    tick();
    chk_all("pwr.resume", S_RUN, 1, 7, 4'b0010, 0);
    for (int k = 8; k < 16; k++) begin
      tick();
      chk_all($sformatf("pwr.c%0d", k), S_RUN, 1, 32'(k), 4'b0010, 0);
    end
    tick();
    chk_all("pwr.adv", S_RUN, 2, 0, 4'b0100, 0);
    cancel = 1'b1; tick(); cancel = 1'b0;

    // Lid opens on the terminal count of phase 0.
    begin_cycle(1);
    for (int k = 0; k < 15; k++) tick();
    chk_all("lid.pre", S_RUN, 0, 15, 4'b0001, 0);
    lid_open = 1'b1;
    tick();
    chk_all("lid.pause", S_PAUSE, 0, 15, 4'b0000, 0);
    lid_open = 1'b0;
    tick();
    chk_all("lid.resume", S_RUN, 0, 15, 4'b0001, 0);
    tick();
    chk_all("lid.adv", S_RUN, 1, 0, 4'b0010, 0);

    // Cancel while paused.
    power_on = 1'b0;
    tick();
    chk_all("cpause.pause", S_PAUSE, 1, 0, 4'b0000, 0);
    cancel = 1'b1; power_on = 1'b1;
    tick();
    cancel = 1'b0;
    chk_all("cpause.idle", S_IDLE, 0, 0, 4'b0000, 0);
    chk("cpause.abort_fault", 32'(abort_fault), 0);

`ifdef WM_PAUSE_TIMEOUT_EN
    begin_cycle(1);
    power_on = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      tick();
      chk($sformatf("tmo.n%0d.state", n), 32'(state), (n <= 20) ? 32'(S_PAUSE) : 32'(S_IDLE));
      chk($sformatf("tmo.n%0d.fault", n), 32'(abort_fault), (n <= 20) ? 0 : 1);
    end
    power_on = 1'b1;
    begin_cycle(1);
    chk_all("tmo.restart", S_RUN, 0, 0, 4'b0001, 0);
    chk("tmo.fault_clr", 32'(abort_fault), 0);
    cancel = 1'b1; tick(); cancel = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
